// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared filter codes, code width and scheduler state type
package filter_pkg;

  localparam int FILTER_W = 2;

  // Filter codes; 2 and 3 are reserved for future filters
  localparam logic [FILTER_W-1:0] SEPIA  = 2'd0;
  localparam logic [FILTER_W-1:0] INVERT = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    AUTO = 2'd2
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector with all-ones history reset
module rise_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] d_prev;

  // History resets to ones so a level already high at reset never fires
  always_ff @(posedge clk) begin
    if (rst) d_prev <= '1;
    else     d_prev <= d;
  end

  assign rise = d & ~d_prev;

endmodule

// File: rtl/filter_sched.sv
// rtl/filter_sched.sv - frame-synchronous filter code scheduler with auto-cycle
module filter_sched #(
  parameter int NUM_FILTERS  = 4,
  parameter int CYCLE_FRAMES = 60,
  parameter int FILTER_W     = filter_pkg::FILTER_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                filters_en,
  input  logic                filters_user_in_en,
  input  logic [3:0]          select,
  input  logic                auto_btn,
  input  logic                vsync,
  output logic [FILTER_W-1:0] filter,
  output logic                pending,
  output logic [FILTER_W-1:0] pending_filter,
  output logic                auto_mode,
  output logic                frame_tick
);

  import filter_pkg::*;

  localparam int CNT_W = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;

  logic [3:0]          sel_rise;
  logic                auto_rise;
  logic                user_ok;
  logic                sel_req;
  logic [FILTER_W-1:0] sel_code;
  logic                auto_req;
  logic [FILTER_W-1:0] next_filter;
  logic [CNT_W-1:0]    cnt;
  state_t              state;

  rise_detect #(.WIDTH(4)) u_sel_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (select),
    .rise (sel_rise)
  );

  rise_detect #(.WIDTH(1)) u_auto_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (auto_btn),
    .rise (auto_rise)
  );

  rise_detect #(.WIDTH(1)) u_vsync_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (vsync),
    .rise (frame_tick)
  );

  assign user_ok = filters_en && filters_user_in_en;

  // Priority-encode select edges: lowest in-range index wins
  always_comb begin
    sel_req  = 1'b0;
    sel_code = '0;
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      if (sel_rise[i] && user_ok) begin
        sel_req  = 1'b1;
        sel_code = FILTER_W'(i);
      end
    end
  end

  // A select request in the same cycle suppresses the auto toggle
  assign auto_req = auto_rise && user_ok && !sel_req;

  assign next_filter = (filter == FILTER_W'(NUM_FILTERS - 1)) ? '0
                                                               : FILTER_W'(filter + 1'b1);

  // Scheduler FSM: filter only ever updates on a frame_tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      filter         <= SEPIA;
      pending_filter <= SEPIA;
      cnt            <= '0;
    end else if (!filters_en) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_req && sel_code != filter) begin
            pending_filter <= sel_code;
            state          <= PEND;
          end else if (auto_req) begin
            cnt   <= '0;
            state <= AUTO;
          end
        end
        PEND: begin
          if (sel_req) begin
            pending_filter <= sel_code;
            if (frame_tick) begin
              filter <= sel_code;
              state  <= IDLE;
            end
          end else if (auto_req) begin
            cnt   <= '0;
            state <= AUTO;
          end else if (frame_tick) begin
            filter <= pending_filter;
            state  <= IDLE;
          end
        end
        AUTO: begin
          if (sel_req) begin
            pending_filter <= sel_code;
            cnt            <= '0;
            state          <= PEND;
          end else if (auto_req) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (frame_tick) begin
            if (cnt == CNT_W'(CYCLE_FRAMES - 1)) begin
              filter <= next_filter;
              cnt    <= '0;
            end else begin
              cnt <= CNT_W'(cnt + 1'b1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pending   = (state == PEND);
  assign auto_mode = (state == AUTO);

endmodule

// File: tb/tb_filter_sched.sv
// tb/tb_filter_sched.sv - scoreboard bench for filter_sched
module tb_filter_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       filters_en;
  logic       filters_user_in_en;
  logic [3:0] select;
  logic       auto_btn;
  logic       vsync;
  logic [1:0] filter;
  logic       pending;
  logic [1:0] pending_filter;
  logic       auto_mode;
  logic       frame_tick;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  // Field mask bits: [4] filter, [3] pending, [2] pending_filter, [1] auto_mode, [0] frame_tick
  typedef struct {
    int         cyc;
    string      name;
    logic [4:0] m;
    logic [1:0] f;
    logic       p;
    logic [1:0] pf;
    logic       a;
    logic       t;
  } exp_t;

  exp_t sb[$];

  filter_sched #(
    .NUM_FILTERS  (4),
    .CYCLE_FRAMES (3),
    .FILTER_W     (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .filters_en         (filters_en),
    .filters_user_in_en (filters_user_in_en),
    .select             (select),
    .auto_btn           (auto_btn),
    .vsync              (vsync),
    .filter             (filter),
    .pending            (pending),
    .pending_filter     (pending_filter),
    .auto_mode          (auto_mode),
    .frame_tick         (frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp(input int d, input string nm, input logic [4:0] m, input logic [1:0] f,
                     input logic p, input logic [1:0] pf, input logic a, input logic t);
    exp_t e;
    e.cyc = cyc + d; e.name = nm; e.m = m;
    e.f = f; e.p = p; e.pf = pf; e.a = a; e.t = t;
    sb.push_back(e);
  endtask

  task automatic vpulse();
    vsync = 1'b1;
    step(); step();
    vsync = 1'b0;
    step(); step();
  endtask

  task automatic cmp(input string nm, input string fld, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s.%s at cycle %0d: got %0d expected %0d", nm, fld, cyc, got, want);
    end
  endtask

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        cmp(e.name, "missed", cyc, e.cyc);
      end else begin
        if (e.m[4]) cmp(e.name, "filter", int'(filter), int'(e.f));
        if (e.m[3]) cmp(e.name, "pending", int'(pending), int'(e.p));
        if (e.m[2]) cmp(e.name, "pending_filter", int'(pending_filter), int'(e.pf));
        if (e.m[1]) cmp(e.name, "auto_mode", int'(auto_mode), int'(e.a));
        if (e.m[0]) cmp(e.name, "frame_tick", int'(frame_tick), int'(e.t));
      end
    end
  end

  initial begin
    rst = 1'b1; filters_en = 1'b1; filters_user_in_en = 1'b1;
    select = 4'b0010; auto_btn = 1'b0; vsync = 1'b0;
    step(); step();
    exp(0, "reset_vals", 5'b11111, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step(); step();
    exp(0, "reset_held_sel", 5'b11111, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    select = 4'b0000;
    step();

    // Manual request waits for the frame boundary
    select = 4'b0010;
    exp(1, "t2_pend", 5'b11110, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
    step();
    select = 4'b0000;
    repeat (5) begin
      step();
      exp(0, "t2_wait", 5'b11001, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    end
    step();
    vsync = 1'b1;
    exp(0, "t2_tick", 5'b11001, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1);
    exp(1, "t2_apply", 5'b11011, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(); step();
    exp(0, "t2_vsync_held", 5'b10001, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    vsync = 1'b0;
    step();

    // Overwrite while pending; last request back to current code
    select = 4'b0001;
    exp(1, "t3_pf0", 5'b01100, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    step();
    select = 4'b0000;
    step();
    select = 4'b0010;
    exp(1, "t3_pf1", 5'b01100, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
    step();
    select = 4'b0000;
    step();
    exp(0, "t3_tick", 5'b11001, 2'd1, 1'b1, 2'd0, 1'b0, 1'b1);
    exp(1, "t3_same", 5'b11000, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    vpulse();

    // Request coinciding with the frame tick while pending is applied directly
    select = 4'b0001;
    exp(1, "t3_pend0", 5'b01100, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    step();
    select = 4'b0000;
    step();
    select = 4'b0100;
    vsync = 1'b1;
    exp(0, "t3_coinc_tick", 5'b10001, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1);
    exp(1, "t3_direct", 5'b11000, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    select = 4'b0000;
    step();
    vsync = 1'b0;
    step(); step();

    // User input not routed here: ignored
    filters_user_in_en = 1'b0;
    select = 4'b0001;
    exp(1, "no_user_in", 5'b11000, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    select = 4'b0000;
    step();
    filters_user_in_en = 1'b1;
    step();

    // Auto mode from filter 3 with 3 frames per step
    select = 4'b1000;
    step();
    select = 4'b0000;
    exp(0, "t4_pf3", 5'b01100, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
    exp(1, "t4_f3", 5'b11000, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
    vpulse();
    auto_btn = 1'b1;
    exp(1, "t4_auto_on", 5'b11010, 2'd3, 1'b0, 2'd0, 1'b1, 1'b0);
    step();
    auto_btn = 1'b0;
    step();
    repeat (2) begin
      exp(1, "t4_hold3", 5'b10010, 2'd3, 1'b0, 2'd0, 1'b1, 1'b0);
      vpulse();
    end
    exp(0, "t4_step_tick", 5'b10001, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1);
    exp(1, "t4_wrap0", 5'b10010, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    vpulse();
    repeat (2) begin
      exp(1, "t4_hold0", 5'b10010, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
      vpulse();
    end
    exp(1, "t4_step1", 5'b10010, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0);
    vpulse();

    // Select in auto mode leaves to pending; no auto step on the applying tick
    repeat (2) begin
      exp(1, "t5_hold1", 5'b10010, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0);
      vpulse();
    end
    select = 4'b0010;
    exp(1, "t5_leave", 5'b01110, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
    step();
    select = 4'b0000;
    step();
    exp(1, "t5_apply", 5'b11010, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
    vpulse();

    // Disable while pending: filter holds, ticks keep running, selects ignored
    select = 4'b0100;
    step();
    select = 4'b0000;
    exp(0, "t6_pf2", 5'b01100, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
    exp(1, "t6_f2", 5'b11000, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    vpulse();
    select = 4'b1001;
    exp(1, "t6_lowest", 5'b01100, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    step();
    select = 4'b0000;
    step();
    filters_en = 1'b0;
    exp(1, "t6_disabled", 5'b11010, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      select = (k == 1) ? 4'b1000 : 4'b0010;
      step();
      select = 4'b0000;
      exp(0, "t6_ignored", 5'b11000, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
      vsync = 1'b1;
      exp(0, "t6_tick", 5'b00001, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
      exp(1, "t6_keep", 5'b11000, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
      vpulse();
    end
    filters_en = 1'b1;
    step();

    // Reset mid-pending discards request and restores filter 0
    select = 4'b0010;
    step();
    select = 4'b0000;
    exp(0, "t7_pend", 5'b01000, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
    rst = 1'b1;
    exp(1, "t7_reset", 5'b11111, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;
    repeat (3) step();

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "never_checked", cyc, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
